// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator and video output stage. Free-running horizontal and
// vertical counters produce pixel coordinates for the shader pipeline. The
// sync/enable flags computed from those counters are delayed by PIPE_DELAY
// enabled cycles, so they line up with the shaded colour returned on rgb_in.
// One final register then drives HSYNC, VSYNC, DE and the blanked RGB.
//
// Ports:
//   clk_25mhz    pixel clock
//   rst          asynchronous, active-high reset
//   en           pixel-clock enable; all state advances only when 1
//   px_x, px_y   scaled pixel coordinates (h_cnt/v_cnt >> SCALE_SHIFT)
//   visible      current counters inside the active area (undelayed)
//   line_start   h_cnt == 0 on an enabled cycle
//   frame_start  h_cnt == 0 && v_cnt == 0 on an enabled cycle
//   rgb_in       shaded pixel {r,g,b}, PIPE_DELAY enabled cycles behind px_x/px_y
//   hsync, vsync sync outputs at the configured polarity (registered)
//   de           display enable (registered)
//   vga_r/g/b    colour outputs, forced to zero outside the active area
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int SCALE_SHIFT = 1,
    parameter int PIPE_DELAY  = 3,
    parameter int CW          = 11
) (
    input  logic          clk_25mhz,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y,
    output logic          visible,
    output logic          line_start,
    output logic          frame_start,
    input  logic [23:0]   rgb_in,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Window bounds kept at 32 bits so an end bound equal to the total cannot
    // overflow a tightly sized CW.
    localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    // -------------------------------------------------------------------------
    // Raster counters
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would let h_cnt's update leak into the
    // v_cnt decision in the same edge.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Coordinates and undelayed status
    // -------------------------------------------------------------------------
    logic hs_raw;
    logic vs_raw;

    assign px_x        = h_cnt >> SCALE_SHIFT;
    assign px_y        = v_cnt >> SCALE_SHIFT;
    assign visible     = (32'(h_cnt) < H_ACT_END) && (32'(v_cnt) < V_ACT_END);
    assign line_start  = (h_cnt == '0) && en;
    assign frame_start = (h_cnt == '0) && (v_cnt == '0) && en;
    assign hs_raw      = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    assign vs_raw      = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);

    // -------------------------------------------------------------------------
    // Delay line matching the shader latency. Bits are {hs, vs, de}, active
    // high, so the cleared value is "inactive".
    // -------------------------------------------------------------------------
    logic [2:0] flags_raw;
    logic [2:0] flags_dly;

    assign flags_raw = {hs_raw, vs_raw, visible};

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign flags_dly = flags_raw;
        end else begin : g_delay
            logic [2:0] stage [PIPE_DELAY];

            // NOTE: the stage array is a handful of flops, not a RAM, so it is
            // reset; otherwise stale sync flags would leak out after reset.
            always_ff @(posedge clk_25mhz or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= '0;
                    end
                end else if (en) begin
                    stage[0] <= flags_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign flags_dly = stage[PIPE_DELAY-1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output register. The mux selects constant zero during blanking, so
    // whatever sits on rgb_in then never reaches the pins.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            de    <= 1'b0;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (en) begin
            hsync                 <= flags_dly[2] ? HS_ON : ~HS_ON;
            vsync                 <= flags_dly[1] ? VS_ON : ~VS_ON;
            de                    <= flags_dly[0];
            {vga_r, vga_g, vga_b} <= flags_dly[0] ? rgb_in : 24'h00_0000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances run side by side: one with default 640x480 timing and one with
// a tiny raster (14 x 8, no pipeline delay, active-high hsync). The reference
// model works from the number of enabled clock edges since reset: the raster
// position is plain modular arithmetic on that count. The registered outputs
// reflect the position PIPE_DELAY+1 enabled edges earlier, and reset values
// apply before that.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int pipe, sh;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic [10:0] px;
        logic [10:0] py;
        logic        vis;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    logic clk_25mhz = 1'b0;
    always #5 clk_25mhz = ~clk_25mhz;

    // default-parameter instance
    logic        d_rst, d_en;
    logic [23:0] d_rgb;
    logic [10:0] d_px, d_py;
    logic        d_vis, d_ls, d_fs, d_hs, d_vs, d_de;
    logic [7:0]  d_r, d_g, d_b;
    logic [23:0] d_vga;
    assign d_vga = {d_r, d_g, d_b};

    // small-raster instance
    logic        s_rst, s_en;
    logic [23:0] s_rgb;
    logic [10:0] s_px, s_py;
    logic        s_vis, s_ls, s_fs, s_hs, s_vs, s_de;
    logic [7:0]  s_r, s_g, s_b;

    int   total = 0;
    int   bad   = 0;
    int   n_def = 0;
    int   n_sml = 0;
    bit   rand_fill = 1'b0;
    cfg_t c_def, c_sml;

    vga_timing_gen u_def (
        .clk_25mhz  (clk_25mhz),
        .rst        (d_rst),
        .en         (d_en),
        .px_x       (d_px),
        .px_y       (d_py),
        .visible    (d_vis),
        .line_start (d_ls),
        .frame_start(d_fs),
        .rgb_in     (d_rgb),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .de         (d_de),
        .vga_r      (d_r),
        .vga_g      (d_g),
        .vga_b      (d_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(0), .SCALE_SHIFT(0), .PIPE_DELAY(0), .CW(11)
    ) u_sml (
        .clk_25mhz  (clk_25mhz),
        .rst        (s_rst),
        .en         (s_en),
        .px_x       (s_px),
        .px_y       (s_py),
        .visible    (s_vis),
        .line_start (s_ls),
        .frame_start(s_fs),
        .rgb_in     (s_rgb),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .de         (s_de),
        .vga_r      (s_r),
        .vga_g      (s_g),
        .vga_b      (s_b)
    );

    // ---------------------------------------------------------------- model
    function automatic int h_tot(cfg_t c);
        return c.ha + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic int v_tot(cfg_t c);
        return c.va + c.vfp + c.vsw + c.vbp;
    endfunction

    function automatic bit is_vis(cfg_t c, int m);
        int h, v;
        h = m % h_tot(c);
        v = (m / h_tot(c)) % v_tot(c);
        return (h < c.ha) && (v < c.va);
    endfunction

    // colour the "shader" returns for raster position m: {x, y, 5A}
    function automatic logic [23:0] rgb_of(cfg_t c, int m);
        int h, v;
        logic [10:0] x, y;
        h = m % h_tot(c);
        v = (m / h_tot(c)) % v_tot(c);
        x = 11'(h >> c.sh);
        y = 11'(v >> c.sh);
        return {x[7:0], y[7:0], 8'h5A};
    endfunction

    function automatic exp_t model(cfg_t c, int n, bit en_v);
        exp_t e;
        int h, v, d, dh, dv;
        bit dhs, dvs, dvis;
        h = n % h_tot(c);
        v = (n / h_tot(c)) % v_tot(c);
        e.px  = 11'(h >> c.sh);
        e.py  = 11'(v >> c.sh);
        e.vis = (h < c.ha) && (v < c.va);
        e.ls  = (h == 0) && en_v;
        e.fs  = (h == 0) && (v == 0) && en_v;
        d = n - 1 - c.pipe;
        if (d < 0) begin
            e.hs  = ~c.hpol;
            e.vs  = ~c.vpol;
            e.de  = 1'b0;
            e.rgb = 24'h0;
        end else begin
            dh   = d % h_tot(c);
            dv   = (d / h_tot(c)) % v_tot(c);
            dhs  = (dh >= c.ha + c.hfp) && (dh < c.ha + c.hfp + c.hsw);
            dvs  = (dv >= c.va + c.vfp) && (dv < c.va + c.vfp + c.vsw);
            dvis = (dh < c.ha) && (dv < c.va);
            e.hs  = dhs ? c.hpol : ~c.hpol;
            e.vs  = dvs ? c.vpol : ~c.vpol;
            e.de  = dvis;
            e.rgb = dvis ? rgb_of(c, d) : 24'h0;
        end
        return e;
    endfunction

    function automatic exp_t obs_def();
        return {d_px, d_py, d_vis, d_ls, d_fs, d_hs, d_vs, d_de, d_vga};
    endfunction

    function automatic exp_t obs_sml();
        return {s_px, s_py, s_vis, s_ls, s_fs, s_hs, s_vs, s_de, s_r, s_g, s_b};
    endfunction

    // ------------------------------------------------------------- drivers
    // Each call: wait for the falling edge, account for the rising edge just
    // passed, apply new inputs, then settle 1 ns so the caller can sample.
    task automatic drive_def(input bit en_v, input bit rst_v);
        int m;
        @(negedge clk_25mhz);
        if (d_en && !d_rst) n_def++;
        d_rst = rst_v;
        if (rst_v) n_def = 0;
        d_en = en_v;
        m = n_def - c_def.pipe;
        if (m >= 0 && is_vis(c_def, m)) d_rgb = rgb_of(c_def, m);
        else d_rgb = rand_fill ? 24'($urandom()) : 24'hFF_FFFF;
        #1;
    endtask

    task automatic drive_sml(input bit en_v, input bit rst_v);
        int m;
        @(negedge clk_25mhz);
        if (s_en && !s_rst) n_sml++;
        s_rst = rst_v;
        if (rst_v) n_sml = 0;
        s_en = en_v;
        m = n_sml - c_sml.pipe;
        if (m >= 0 && is_vis(c_sml, m)) s_rgb = rgb_of(c_sml, m);
        else s_rgb = rand_fill ? 24'($urandom()) : 24'hFF_FFFF;
        #1;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        d_rst = 1'b1; s_rst = 1'b1;
        d_en  = 1'b0; s_en  = 1'b0;
        d_rgb = 24'hFF_FFFF; s_rgb = 24'hFF_FFFF;
        repeat (3) @(negedge clk_25mhz);
        #1;
        total++;
        if ({d_hs, d_vs, d_de, d_vga} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
            bad++;
            $display("FAIL reset_def_out got=%h exp=%h", {d_hs, d_vs, d_de, d_vga}, {1'b1, 1'b1, 1'b0, 24'h0});
        end
        total++;
        if ({s_hs, s_vs, s_de, s_r, s_g, s_b} !== {1'b0, 1'b1, 1'b0, 24'h0}) begin
            bad++;
            $display("FAIL reset_sml_out got=%h exp=%h", {s_hs, s_vs, s_de, s_r, s_g, s_b}, {1'b0, 1'b1, 1'b0, 24'h0});
        end
        // en high while still in reset: nothing may move
        repeat (3) begin
            drive_def(1'b1, 1'b1);
            total++;
            if (obs_def() !== model(c_def, n_def, d_en)) begin
                bad++;
                $display("FAIL reset_hold got=%h exp=%h", obs_def(), model(c_def, n_def, d_en));
            end
        end
    endtask

    task automatic test_default_line();
        exp_t e;
        int first_low, first_de, low_cnt;
        first_low = -1; first_de = -1; low_cnt = 0;
        rand_fill = 1'b0;
        repeat (1700) begin
            drive_def(1'b1, 1'b0);
            e = model(c_def, n_def, d_en);
            total++;
            if (obs_def() !== e) begin
                bad++;
                $display("FAIL def_line n=%0d got=%h exp=%h", n_def, obs_def(), e);
            end
            if (!d_hs && first_low < 0) first_low = n_def;
            if (d_de && first_de < 0) first_de = n_def;
            if (n_def >= 800 && n_def < 1600 && !d_hs) low_cnt++;
            if (n_def == 0) begin
                total++;
                if ({d_px, d_py, d_fs, d_vis} !== {11'd0, 11'd0, 1'b1, 1'b1}) begin
                    bad++;
                    $display("FAIL first_cycle got=%h exp=%h", {d_px, d_py, d_fs, d_vis}, {11'd0, 11'd0, 1'b1, 1'b1});
                end
            end
            if (n_def == 4) begin
                total++;
                if ({d_de, d_vga} !== {1'b1, 24'h00_005A}) begin
                    bad++;
                    $display("FAIL first_de_rgb got=%h exp=%h", {d_de, d_vga}, {1'b1, 24'h00_005A});
                end
            end
            if (n_def == 644) begin
                total++;
                if ({d_de, d_vga} !== 25'h0) begin
                    bad++;
                    $display("FAIL blank_after_line got=%h exp=0 rgb_in=%h", {d_de, d_vga}, d_rgb);
                end
            end
        end
        total++;
        if (first_de != 4) begin
            bad++;
            $display("FAIL de_latency got=%0d exp=4", first_de);
        end
        total++;
        if (first_low != 660) begin
            bad++;
            $display("FAIL hsync_first_low got=%0d exp=660", first_low);
        end
        total++;
        if (low_cnt != 96) begin
            bad++;
            $display("FAIL hsync_width got=%0d exp=96", low_cnt);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int target;
        target = 17 * 800 + 300;
        for (int i = 0; i < 20000 && n_def < target; i++) begin
            drive_def(1'b1, 1'b0);
            e = model(c_def, n_def, d_en);
            total++;
            if (obs_def() !== e) begin
                bad++;
                $display("FAIL def_run n=%0d got=%h exp=%h", n_def, obs_def(), e);
            end
        end
        total++;
        if (d_de !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_de got=%b exp=1", d_de);
        end
        #2 d_rst = 1'b1;
        #1;
        total++;
        if ({d_hs, d_vs, d_de, d_vga, d_px, d_py} !== {1'b1, 1'b1, 1'b0, 24'h0, 11'd0, 11'd0}) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", {d_hs, d_vs, d_de, d_vga, d_px, d_py},
                     {1'b1, 1'b1, 1'b0, 24'h0, 11'd0, 11'd0});
        end
        drive_def(1'b1, 1'b1);
        for (int i = 0; i < 900; i++) begin
            drive_def(1'b1, 1'b0);
            e = model(c_def, n_def, d_en);
            total++;
            if (obs_def() !== e) begin
                bad++;
                $display("FAIL def_restart n=%0d got=%h exp=%h", n_def, obs_def(), e);
            end
        end
    endtask

    task automatic test_small_frame();
        exp_t e;
        int hs_cnt, vs_cnt, fs_cnt;
        hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        drive_sml(1'b1, 1'b1);
        repeat (336) begin
            drive_sml(1'b1, 1'b0);
            e = model(c_sml, n_sml, s_en);
            total++;
            if (obs_sml() !== e) begin
                bad++;
                $display("FAIL sml_frame n=%0d got=%h exp=%h", n_sml, obs_sml(), e);
            end
            if (n_sml >= 112 && n_sml < 126 && s_hs) hs_cnt++;
            if (n_sml >= 112 && n_sml < 224 && !s_vs) vs_cnt++;
            if (n_sml >= 112 && n_sml < 224 && s_fs) fs_cnt++;
        end
        total++;
        if (hs_cnt != 3) begin
            bad++;
            $display("FAIL sml_hsync_width got=%0d exp=3", hs_cnt);
        end
        total++;
        if (vs_cnt != 28) begin
            bad++;
            $display("FAIL sml_vsync_width got=%0d exp=28", vs_cnt);
        end
        total++;
        if (fs_cnt != 1) begin
            bad++;
            $display("FAIL sml_frame_starts got=%0d exp=1", fs_cnt);
        end
    endtask

    task automatic test_en_toggle();
        exp_t e;
        int fs_a, fs_b, hs_cnt;
        fs_a = -1; fs_b = -1; hs_cnt = 0;
        drive_sml(1'b1, 1'b1);
        for (int k = 0; k < 480; k++) begin
            drive_sml((k % 2) == 0, 1'b0);
            e = model(c_sml, n_sml, s_en);
            total++;
            if (obs_sml() !== e) begin
                bad++;
                $display("FAIL en_toggle k=%0d got=%h exp=%h", k, obs_sml(), e);
            end
            if (s_fs) begin
                if (fs_a < 0) fs_a = k;
                else if (fs_b < 0) fs_b = k;
            end
            if (k >= 224 && k < 252 && s_hs) hs_cnt++;
        end
        total++;
        if (fs_b - fs_a != 224) begin
            bad++;
            $display("FAIL en_toggle_frame got=%0d exp=224", fs_b - fs_a);
        end
        total++;
        if (hs_cnt != 6) begin
            bad++;
            $display("FAIL en_toggle_hsync got=%0d exp=6", hs_cnt);
        end
    endtask

    task automatic test_random_en();
        exp_t e;
        rand_fill = 1'b1;
        drive_sml(1'b1, 1'b1);
        drive_def(1'b1, 1'b1);
        repeat (400) begin
            drive_sml(1'($urandom_range(0, 1)), 1'b0);
            e = model(c_sml, n_sml, s_en);
            total++;
            if (obs_sml() !== e) begin
                bad++;
                $display("FAIL sml_rand n=%0d got=%h exp=%h", n_sml, obs_sml(), e);
            end
        end
        repeat (1200) begin
            drive_def(1'($urandom_range(0, 3) != 0), 1'b0);
            e = model(c_def, n_def, d_en);
            total++;
            if (obs_def() !== e) begin
                bad++;
                $display("FAIL def_rand n=%0d got=%h exp=%h", n_def, obs_def(), e);
            end
        end
    endtask

    initial begin
        c_def = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33,
                  pipe:3, sh:1, hpol:1'b0, vpol:1'b0};
        c_sml = '{ha:8, hfp:2, hsw:3, hbp:1, va:4, vfp:1, vsw:2, vbp:1,
                  pipe:0, sh:0, hpol:1'b1, vpol:1'b0};
        test_reset();
        test_default_line();
        test_reset_mid();
        test_small_frame();
        test_en_toggle();
        test_random_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
